// File: rtl/core101_ctrl_pkg.sv
// Shared encodings for the Core101 control sequencer: states, opcodes,
// PC source selects, trap causes and opcode classes.
package core101_ctrl_pkg;

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_PC_UPDATE,
    S_TRAP
  } ctrl_state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] PCSEL_PC4 = 2'b00;
  localparam logic [1:0] PCSEL_IMM = 2'b01;
  localparam logic [1:0] PCSEL_ALU = 2'b10;
  localparam logic [1:0] PCSEL_RST = 2'b11;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_SYSTEM  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  typedef enum logic [3:0] {
    CLS_NONE,
    CLS_LUI,
    CLS_AUIPC,
    CLS_JAL,
    CLS_JALR,
    CLS_BRANCH,
    CLS_LOAD,
    CLS_STORE,
    CLS_OPIMM,
    CLS_OP,
    CLS_FENCE,
    CLS_SYSTEM
  } opc_class_e;

endpackage

// File: rtl/core101_opcode_class.sv
// Combinational RV32I opcode classifier: class code plus illegal flag.
module core101_opcode_class
  import core101_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [3:0] cls,
  output logic       illegal
);

  always_comb begin
    cls     = CLS_NONE;
    illegal = 1'b0;
    case (opcode)
      OPC_LUI:    cls = CLS_LUI;
      OPC_AUIPC:  cls = CLS_AUIPC;
      OPC_JAL:    cls = CLS_JAL;
      OPC_JALR:   cls = CLS_JALR;
      OPC_BRANCH: cls = CLS_BRANCH;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_OPIMM:  cls = CLS_OPIMM;
      OPC_OP:     cls = CLS_OP;
      OPC_FENCE:  cls = CLS_FENCE;
      OPC_SYSTEM: cls = CLS_SYSTEM;
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/core101_control_fsm.sv
// Multi-cycle sequencer for the Core101 RV32I datapath: fetch/decode/execute
// control strobes, bus wait timeout, trap latching and retired-instruction count.
module core101_control_fsm
  import core101_ctrl_pkg::*;
#(
  parameter int BUS_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic        ctrl_clock_in,
  input  logic        ctrl_reset_in,
  input  logic [6:0]  ctrl_opcode_in,
  input  logic        ctrl_funct12_bit_in,
  input  logic        ctrl_branch_taken_in,
  input  logic        ctrl_ins_ready_in,
  input  logic        ctrl_mem_ready_in,
  output logic        ctrl_ins_req_out,
  output logic        ctrl_ir_set_val_out,
  output logic        ctrl_pc_set_val_out,
  output logic [1:0]  ctrl_pc_mux_sel_out,
  output logic        ctrl_rf_write_out,
  output logic        ctrl_mem_req_out,
  output logic        ctrl_mem_we_out,
  output logic        ctrl_halted_out,
  output logic [1:0]  ctrl_trap_cause_out,
  output logic [31:0] ctrl_instret_out
);

  ctrl_state_e      state_q, state_d;
  opc_class_e       cls_q;
  logic [3:0]       cls_raw;
  logic             illegal;
  logic             taken_q;
  logic [CNT_W-1:0] wait_q;
  logic [CNT_W:0]   wait_inc;
  logic             bus_tmo;
  logic [1:0]       cause_q, cause_d;
  logic [31:0]      instret_q;
  logic             unused_funct12;

  // SYSTEM is legal for both ECALL and EBREAK, so IR[20] never matters here.
  assign unused_funct12 = ctrl_funct12_bit_in;

  core101_opcode_class u_cls (
    .opcode  (ctrl_opcode_in),
    .cls     (cls_raw),
    .illegal (illegal)
  );

  // Trap on the cycle that would make the low-ready count reach the limit;
  // a ready in that same cycle takes priority.
  assign wait_inc = {1'b0, wait_q} + (CNT_W+1)'(1);
  assign bus_tmo  = wait_inc >= (CNT_W+1)'(BUS_TIMEOUT);

  always_comb begin
    state_d             = state_q;
    cause_d             = cause_q;
    ctrl_ins_req_out    = 1'b0;
    ctrl_ir_set_val_out = 1'b0;
    ctrl_pc_set_val_out = 1'b0;
    ctrl_pc_mux_sel_out = PCSEL_PC4;
    ctrl_rf_write_out   = 1'b0;
    ctrl_mem_req_out    = 1'b0;
    ctrl_mem_we_out     = 1'b0;
    case (state_q)
      S_BOOT: begin
        ctrl_pc_set_val_out = 1'b1;
        ctrl_pc_mux_sel_out = PCSEL_RST;
        state_d             = S_FETCH;
      end
      S_FETCH: begin
        ctrl_ins_req_out = 1'b1;
        if (ctrl_ins_ready_in) begin
          ctrl_ir_set_val_out = 1'b1;
          state_d             = S_DECODE;
        end else if (bus_tmo) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (illegal) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else if (cls_raw == CLS_SYSTEM) begin
          state_d = S_TRAP;
          cause_d = CAUSE_SYSTEM;
        end else if (cls_raw == CLS_FENCE) begin
          state_d = S_PC_UPDATE;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        case (cls_q)
          CLS_LOAD, CLS_STORE: state_d = S_MEM;
          CLS_BRANCH:          state_d = S_PC_UPDATE;
          default:             state_d = S_WRITEBACK;
        endcase
      end
      S_MEM: begin
        ctrl_mem_req_out = 1'b1;
        ctrl_mem_we_out  = (cls_q == CLS_STORE);
        if (ctrl_mem_ready_in) begin
          state_d = (cls_q == CLS_STORE) ? S_PC_UPDATE : S_WRITEBACK;
        end else if (bus_tmo) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_WRITEBACK: begin
        ctrl_rf_write_out = 1'b1;
        state_d           = S_PC_UPDATE;
      end
      S_PC_UPDATE: begin
        ctrl_pc_set_val_out = 1'b1;
        state_d             = S_FETCH;
        case (cls_q)
          CLS_JAL:    ctrl_pc_mux_sel_out = PCSEL_IMM;
          CLS_JALR:   ctrl_pc_mux_sel_out = PCSEL_ALU;
          CLS_BRANCH: ctrl_pc_mux_sel_out = taken_q ? PCSEL_IMM : PCSEL_PC4;
          default:    ctrl_pc_mux_sel_out = PCSEL_PC4;
        endcase
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_BOOT;
    endcase
    // Reset masks every strobe combinationally so an in-flight request drops at once.
    if (ctrl_reset_in) begin
      ctrl_ins_req_out    = 1'b0;
      ctrl_ir_set_val_out = 1'b0;
      ctrl_pc_set_val_out = 1'b0;
      ctrl_pc_mux_sel_out = PCSEL_RST;
      ctrl_rf_write_out   = 1'b0;
      ctrl_mem_req_out    = 1'b0;
      ctrl_mem_we_out     = 1'b0;
    end
  end

  always_ff @(posedge ctrl_clock_in) begin
    if (ctrl_reset_in) begin
      state_q   <= S_BOOT;
      cause_q   <= CAUSE_NONE;
      wait_q    <= '0;
      instret_q <= '0;
      cls_q     <= CLS_NONE;
      taken_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (state_d != state_q)
        wait_q <= '0;
      else if (state_q == S_FETCH || state_q == S_MEM)
        wait_q <= wait_inc[CNT_W-1:0];
      if (state_q == S_DECODE)    cls_q     <= opc_class_e'(cls_raw);
      if (state_q == S_EXECUTE)   taken_q   <= ctrl_branch_taken_in;
      if (state_q == S_PC_UPDATE) instret_q <= instret_q + 32'd1;
    end
  end

  assign ctrl_halted_out     = (state_q == S_TRAP) && !ctrl_reset_in;
  assign ctrl_trap_cause_out = ctrl_reset_in ? CAUSE_NONE : cause_q;
  assign ctrl_instret_out    = ctrl_reset_in ? 32'd0 : instret_q;

endmodule

// File: tb/tb_core101_control_fsm.sv
// Scoreboard bench for core101_control_fsm: per-instruction expectations are
// queued at stimulus time and compared once the DUT reaches PC_UPDATE.
module tb_core101_control_fsm;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst, f12, taken, ins_ready, mem_ready;
  logic [6:0]  opcode;
  logic        ins_req, ir_set, pc_set, rf_wr, mem_req, mem_we, halted;
  logic [1:0]  mux, cause;
  logic [31:0] instret;
  logic [31:0] exp_instret;
  int          n_tests = 0;
  int          n_fail  = 0;

  typedef struct {
    int         cycles;
    int         rf;
    int         mreq;
    int         mwe;
    logic [1:0] mux;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  core101_control_fsm #(.BUS_TIMEOUT(TMO), .CNT_W(8)) dut (
    .ctrl_clock_in        (clk),
    .ctrl_reset_in        (rst),
    .ctrl_opcode_in       (opcode),
    .ctrl_funct12_bit_in  (f12),
    .ctrl_branch_taken_in (taken),
    .ctrl_ins_ready_in    (ins_ready),
    .ctrl_mem_ready_in    (mem_ready),
    .ctrl_ins_req_out     (ins_req),
    .ctrl_ir_set_val_out  (ir_set),
    .ctrl_pc_set_val_out  (pc_set),
    .ctrl_pc_mux_sel_out  (mux),
    .ctrl_rf_write_out    (rf_wr),
    .ctrl_mem_req_out     (mem_req),
    .ctrl_mem_we_out      (mem_we),
    .ctrl_halted_out      (halted),
    .ctrl_trap_cause_out  (cause),
    .ctrl_instret_out     (instret)
  );

  // Cycles counted from the first FETCH cycle through PC_UPDATE inclusive.
  function automatic exp_t model(input logic [6:0] op, input logic tk, input int iw, input int mw);
    exp_t e;
    e.cycles = 0; e.rf = 0; e.mreq = 0; e.mwe = 0; e.mux = 2'b00;
    case (op)
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: begin e.cycles = 5; e.rf = 1; end
      7'b1101111: begin e.cycles = 5; e.rf = 1; e.mux = 2'b01; end
      7'b1100111: begin e.cycles = 5; e.rf = 1; e.mux = 2'b10; end
      7'b1100011: begin e.cycles = 4; e.mux = tk ? 2'b01 : 2'b00; end
      7'b0001111: e.cycles = 3;
      7'b0000011: begin e.cycles = 6 + mw; e.rf = 1; e.mreq = mw + 1; end
      7'b0100011: begin e.cycles = 5 + mw; e.mreq = mw + 1; e.mwe = mw + 1; end
      default:    e.cycles = 0;
    endcase
    e.cycles += iw;
    return e;
  endfunction

  task automatic apply_reset();
    rst = 1'b1; ins_ready = 1'b1; mem_ready = 1'b1; taken = 1'b0; f12 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_instret = 32'd0;
    sb.delete();
  endtask

  task automatic run_instr(input logic [6:0] op, input logic tk, input int iw, input int mw, input string name);
    exp_t e, g;
    int cyc, n_ins, n_ir;
    bit done;
    sb.push_back(model(op, tk, iw, mw));
    opcode = op; taken = tk;
    cyc = 0; n_ins = 0; n_ir = 0; done = 0;
    g.cycles = 0; g.rf = 0; g.mreq = 0; g.mwe = 0; g.mux = 2'bxx;
    while (!done && cyc < 100) begin
      @(negedge clk);
      ins_ready = (n_ins >= iw);
      mem_ready = (g.mreq >= mw);
      #1;
      if (ins_req) n_ins++;
      if (ir_set) n_ir++;
      if (mem_req) begin g.mreq++; if (mem_we) g.mwe++; end
      if (rf_wr) g.rf++;
      cyc++;
      if (pc_set) begin g.mux = mux; done = 1; end
    end
    @(posedge clk); #1;
    exp_instret = exp_instret + 32'd1;
    e = sb.pop_front();
    n_tests++; if (cyc !== e.cycles) begin n_fail++; $display("FAIL %s cycles got %0d exp %0d", name, cyc, e.cycles); end
    n_tests++; if (g.rf !== e.rf) begin n_fail++; $display("FAIL %s rf_write got %0d exp %0d", name, g.rf, e.rf); end
    n_tests++; if (g.mreq !== e.mreq) begin n_fail++; $display("FAIL %s mem_req got %0d exp %0d", name, g.mreq, e.mreq); end
    n_tests++; if (g.mwe !== e.mwe) begin n_fail++; $display("FAIL %s mem_we got %0d exp %0d", name, g.mwe, e.mwe); end
    n_tests++; if (g.mux !== e.mux) begin n_fail++; $display("FAIL %s pc_mux_sel got %b exp %b", name, g.mux, e.mux); end
    n_tests++; if (n_ir !== 1) begin n_fail++; $display("FAIL %s ir_set_val got %0d exp 1", name, n_ir); end
    n_tests++; if (instret !== exp_instret) begin n_fail++; $display("FAIL %s instret got %0d exp %0d", name, instret, exp_instret); end
  endtask

  task automatic test_reset();
    rst = 1'b1; opcode = 7'b0110011; ins_ready = 1'b1; mem_ready = 1'b1; taken = 1'b0; f12 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_tests++;
    if ({ins_req, ir_set, pc_set, rf_wr, mem_req, mem_we, halted} !== 7'b0 || mux !== 2'b11) begin
      n_fail++; $display("FAIL reset_outputs got strobes %b mux %b exp 0000000 11",
                         {ins_req, ir_set, pc_set, rf_wr, mem_req, mem_we, halted}, mux);
    end
    n_tests++; if (instret !== 32'd0 || cause !== 2'b00) begin n_fail++; $display("FAIL reset_counters got instret %0d cause %b exp 0 00", instret, cause); end
    rst = 1'b0; #1;
    n_tests++;
    if (pc_set !== 1'b1 || mux !== 2'b11 || ins_req !== 1'b0) begin
      n_fail++; $display("FAIL boot got pc_set %b mux %b ins_req %b exp 1 11 0", pc_set, mux, ins_req);
    end
    exp_instret = 32'd0;
    run_instr(7'b0110011, 1'b0, 0, 0, "op_first");
  endtask

  task automatic test_load();
    run_instr(7'b0000011, 1'b0, 0, 3, "load_wait3");
  endtask

  task automatic test_branch();
    run_instr(7'b1100011, 1'b1, 0, 0, "branch_taken");
    run_instr(7'b1100011, 1'b0, 0, 0, "branch_not_taken");
  endtask

  task automatic test_jump_store();
    run_instr(7'b1100111, 1'b0, 0, 0, "jalr");
    run_instr(7'b1101111, 1'b1, 0, 0, "jal");
    run_instr(7'b0100011, 1'b0, 0, 1, "store_wait1");
  endtask

  task automatic test_back_to_back();
    run_instr(7'b0110111, 1'b0, 2, 0, "lui_fetch_wait2");
    run_instr(7'b0010111, 1'b1, 0, 0, "auipc");
    run_instr(7'b0010011, 1'b0, TMO - 1, 0, "opimm_fetch_edge");
    run_instr(7'b0001111, 1'b0, 0, 0, "fence");
    run_instr(7'b0000011, 1'b0, 0, TMO - 1, "load_mem_edge");
  endtask

  task automatic test_trap(input logic [6:0] op, input int iw, input int mw, input logic [1:0] exp_cause,
                           input int exp_cyc, input string name);
    int cyc, hit, n_ins, n_mem;
    apply_reset();
    opcode = op; cyc = 0; hit = -1; n_ins = 0; n_mem = 0;
    while (hit < 0 && cyc < 100) begin
      @(negedge clk);
      ins_ready = (n_ins >= iw);
      mem_ready = (n_mem >= mw);
      #1;
      if (halted) hit = cyc;
      else begin
        if (ins_req) n_ins++;
        if (mem_req) n_mem++;
      end
      cyc++;
    end
    n_tests++; if (hit !== exp_cyc) begin n_fail++; $display("FAIL %s trap_cycle got %0d exp %0d", name, hit, exp_cyc); end
    n_tests++; if (cause !== exp_cause) begin n_fail++; $display("FAIL %s cause got %b exp %b", name, cause, exp_cause); end
    ins_ready = 1'b1; mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      n_tests++;
      if ({ins_req, ir_set, pc_set, rf_wr, mem_req, mem_we} !== 6'b0 || halted !== 1'b1 || cause !== exp_cause) begin
        n_fail++; $display("FAIL %s halted_quiet got strobes %b halted %b cause %b exp 000000 1 %b",
                           name, {ins_req, ir_set, pc_set, rf_wr, mem_req, mem_we}, halted, cause, exp_cause);
      end
    end
    n_tests++; if (instret !== 32'd0) begin n_fail++; $display("FAIL %s instret got %0d exp 0", name, instret); end
  endtask

  task automatic test_faults();
    test_trap(7'b1111111, 0, 0, 2'b01, 2, "illegal");
    test_trap(7'b1110011, 0, 0, 2'b10, 2, "system");
    test_trap(7'b0000011, 0, 1000, 2'b11, 3 + TMO, "mem_timeout");
    test_trap(7'b0110011, 1000, 0, 2'b11, TMO, "fetch_timeout");
  endtask

  task automatic test_reset_mid_mem();
    int cyc;
    apply_reset();
    run_instr(7'b0110011, 1'b0, 0, 0, "op_before_mem");
    opcode = 7'b0000011; cyc = 0;
    mem_ready = 1'b0;
    do begin
      @(negedge clk); #1; cyc++;
    end while (!mem_req && cyc < 20);
    n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL mid_mem reach got mem_req %b exp 1", mem_req); end
    rst = 1'b1; #1;
    n_tests++;
    if (mem_req !== 1'b0 || mux !== 2'b11 || instret !== 32'd0) begin
      n_fail++; $display("FAIL mid_mem drop got mem_req %b mux %b instret %0d exp 0 11 0", mem_req, mux, instret);
    end
    @(negedge clk);
    rst = 1'b0; #1;
    n_tests++;
    if (pc_set !== 1'b1 || mux !== 2'b11 || instret !== 32'd0 || cause !== 2'b00 || halted !== 1'b0) begin
      n_fail++; $display("FAIL mid_mem boot got pc_set %b mux %b instret %0d cause %b halted %b exp 1 11 0 00 0",
                         pc_set, mux, instret, cause, halted);
    end
    exp_instret = 32'd0;
    mem_ready = 1'b1;
    run_instr(7'b0100011, 1'b0, 0, 0, "store_after_reset");
  endtask

  initial begin
    exp_instret = 32'd0;
    test_reset();
    test_load();
    test_branch();
    test_jump_store();
    test_back_to_back();
    test_faults();
    test_reset_mid_mem();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
